// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory arbiter.
package memory_arbiter_pkg;

   // State codes for the bus sequencer.
   typedef enum logic [1:0] {
      ARB_IDLE      = 2'd0,
      ARB_GRANT_IF  = 2'd1,
      ARB_GRANT_MEM = 2'd2
   } arb_state_e;

   // Default number of wait cycles before an access is aborted.
   localparam int ARB_TIMEOUT_DEF = 255;

   // Width of the watchdog counter; never narrower than one bit so that a
   // disabled watchdog (timeout 0) still yields a legal vector.
   function automatic int cnt_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Pipeline-side and bus-side signals of the memory arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface memory_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   // Instruction fetch port
   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic [DATA_WIDTH-1:0] if_rdata;
   logic                  if_stall;
   // MEM stage port
   logic                  m_mem_read;
   logic                  m_mem_write;
   logic [ADDR_WIDTH-1:0] m_addr;
   logic [DATA_WIDTH-1:0] m_wdata;
   logic [DATA_WIDTH-1:0] m_rdata;
   logic                  m_stall;
   // Shared memory bus
   logic                  bus_req;
   logic                  bus_we;
   logic [ADDR_WIDTH-1:0] bus_addr;
   logic [DATA_WIDTH-1:0] bus_wdata;
   logic [DATA_WIDTH-1:0] bus_rdata;
   logic                  bus_ready;
   logic                  bus_error;

   modport slave (
      input  if_req, if_addr, m_mem_read, m_mem_write, m_addr, m_wdata,
             bus_rdata, bus_ready,
      output if_rdata, if_stall, m_rdata, m_stall,
             bus_req, bus_we, bus_addr, bus_wdata, bus_error
   );

   modport master (
      output if_req, if_addr, m_mem_read, m_mem_write, m_addr, m_wdata,
             bus_rdata, bus_ready,
      input  if_rdata, if_stall, m_rdata, m_stall,
             bus_req, bus_we, bus_addr, bus_wdata, bus_error
   );

endinterface

// File: rtl/memory_arbiter_bus_watchdog.sv
// Wait-cycle counter with a sticky error flag. expire_o flags the cycle in
// which an outstanding access has waited TIMEOUT cycles without completing.
module memory_arbiter_bus_watchdog
   import memory_arbiter_pkg::*;
#(
   parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear_i,   // no access outstanding: restart the count
   input  logic count_i,   // access outstanding and not completing this cycle
   output logic expire_o,
   output logic error_o
);

   localparam int CW = cnt_width(TIMEOUT);
   localparam bit ENABLED = (TIMEOUT != 0);

   logic [CW-1:0] wait_cnt_q;
   logic          error_q;

   assign expire_o = ENABLED && count_i && (wait_cnt_q == CW'(TIMEOUT));
   assign error_o  = error_q;

   // Count stalled grant cycles; latch an error the first time one expires.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt_q <= '0;
         error_q    <= 1'b0;
      end else begin
         // NOTE: state is updated with <= so every register samples the
         // pre-edge values; blocking here would make ordering matter.
         if (clear_i) begin
            wait_cnt_q <= '0;
         end else if (ENABLED && count_i && !expire_o) begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
         end
         if (expire_o) begin
            error_q <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port, variable-latency memory bus between instruction
// fetch and the MEM stage. MEM has fixed priority because it holds the older
// instruction. Each access runs IDLE -> GRANT_x -> IDLE; the matching done
// flag pulses for one cycle so the requesting stage can advance.
module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = ARB_TIMEOUT_DEF
) (
   input  logic             clock,
   input  logic             reset_n,
   memory_arbiter_if.slave  arb
);

   arb_state_e            state_q;
   logic                  bus_req_q;
   logic                  bus_we_q;
   logic [ADDR_WIDTH-1:0] bus_addr_q;
   logic [DATA_WIDTH-1:0] bus_wdata_q;
   logic [DATA_WIDTH-1:0] if_rdata_q;
   logic [DATA_WIDTH-1:0] m_rdata_q;
   logic                  if_done_q;
   logic                  m_done_q;

   logic                  m_want;
   logic                  if_want;
   logic                  in_grant;
   logic                  finish;
   logic [DATA_WIDTH-1:0] fin_data;
   logic                  wd_expire;
   logic                  wd_error;

   // A requester is eligible only while its previous access is not in its
   // done cycle; that cycle is when the stage advances to the next access.
   assign m_want   = (arb.m_mem_read | arb.m_mem_write) & ~m_done_q;
   assign if_want  = arb.if_req & ~if_done_q;
   assign in_grant = (state_q != ARB_IDLE);

   // An access ends on bus_ready, or on watchdog expiry with data forced to 0.
   assign finish   = in_grant & (arb.bus_ready | wd_expire);
   assign fin_data = arb.bus_ready ? arb.bus_rdata : '0;

   memory_arbiter_bus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clock    (clock),
      .reset_n  (reset_n),
      .clear_i  (~in_grant),
      .count_i  (in_grant & ~arb.bus_ready),
      .expire_o (wd_expire),
      .error_o  (wd_error)
   );

   // Bus sequencer: arbitrate in IDLE, hold the bus during a grant, retire.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the data registers are reset too: if_rdata = 0 decodes as a
         // NOP, so the pipeline never sees garbage after reset.
         state_q     <= ARB_IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         if_rdata_q  <= '0;
         m_rdata_q   <= '0;
         if_done_q   <= 1'b0;
         m_done_q    <= 1'b0;
      end else begin
         if_done_q <= 1'b0;
         m_done_q  <= 1'b0;
         unique case (state_q)
            ARB_IDLE: begin
               if (m_want) begin
                  state_q     <= ARB_GRANT_MEM;
                  bus_req_q   <= 1'b1;
                  bus_we_q    <= arb.m_mem_write;  // read+write acts as write
                  bus_addr_q  <= arb.m_addr;
                  bus_wdata_q <= arb.m_wdata;
               end else if (if_want) begin
                  state_q    <= ARB_GRANT_IF;
                  bus_req_q  <= 1'b1;
                  bus_we_q   <= 1'b0;
                  bus_addr_q <= arb.if_addr;
               end
            end
            ARB_GRANT_MEM: begin
               if (finish) begin
                  state_q   <= ARB_IDLE;
                  bus_req_q <= 1'b0;
                  m_done_q  <= 1'b1;
                  if (!bus_we_q) begin
                     m_rdata_q <= fin_data;
                  end
               end
            end
            ARB_GRANT_IF: begin
               if (finish) begin
                  state_q   <= ARB_IDLE;
                  bus_req_q <= 1'b0;
                  // A flushed fetch still completes on the bus, but its data
                  // is dropped and the fetch stage is not told it finished.
                  if (arb.if_req) begin
                     if_done_q  <= 1'b1;
                     if_rdata_q <= fin_data;
                  end
               end
            end
            default: begin
               state_q   <= ARB_IDLE;
               bus_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign arb.bus_req   = bus_req_q;
   assign arb.bus_we    = bus_we_q;
   assign arb.bus_addr  = bus_addr_q;
   assign arb.bus_wdata = bus_wdata_q;
   assign arb.bus_error = wd_error;
   assign arb.if_rdata  = if_rdata_q;
   assign arb.m_rdata   = m_rdata_q;
   assign arb.if_stall  = if_want;
   assign arb.m_stall   = m_want;

endmodule
